// File: rtl/trap_ctrl.sv
// trap_ctrl: trap sequencer and write-port arbiter for the machine-mode CSR file.
//
// Owns the single CSR write port. In IDLE it arbitrates between ecall entry,
// mret return, timer interrupt entry and pass-through instruction CSR writes.
// Trap sequences write mepc, mcause and mstatus on consecutive cycles, then
// redirect the IFU to mtvec. mret rewrites mstatus and redirects to mepc.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   exc_valid/exc_pc/exc_cause  ecall request (held until exc_ack)
//   mret_valid                  mret request (held until mret_ack)
//   irq, irq_pc                 level timer interrupt and its mepc value
//   ins_csr_req/addr/wdata      instruction CSR write request (held until ins_csr_gnt)
//   csr_rdata                   combinational CSR read data for csr_raddr
//   exc_ack, mret_ack           one-cycle acceptance pulses
//   ins_csr_gnt                 one-cycle grant for the instruction CSR write
//   csr_we/waddr/wdata          CSR file write port
//   csr_raddr                   CSR file read address (0 when unused)
//   redirect_valid/redirect_pc  one-cycle PC redirect to the IFU
//   busy                        high in every non-IDLE state

module trap_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exc_valid,
    input  logic [31:0] exc_pc,
    input  logic [31:0] exc_cause,
    input  logic        mret_valid,
    input  logic        irq,
    input  logic [31:0] irq_pc,
    input  logic        ins_csr_req,
    input  logic [11:0] ins_csr_addr,
    input  logic [31:0] ins_csr_wdata,
    input  logic [31:0] csr_rdata,
    output logic        exc_ack,
    output logic        mret_ack,
    output logic        ins_csr_gnt,
    output logic        csr_we,
    output logic [11:0] csr_waddr,
    output logic [31:0] csr_wdata,
    output logic [11:0] csr_raddr,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    localparam logic [11:0] CsrMstatus = 12'h300;
    localparam logic [11:0] CsrMtvec   = 12'h305;
    localparam logic [11:0] CsrMepc    = 12'h341;
    localparam logic [11:0] CsrMcause  = 12'h342;

    localparam logic [31:0] IrqCause   = 32'h8000_0007;

    typedef enum logic [2:0] {
        StIdle,
        StTEpc,
        StTCause,
        StTStatus,
        StTVec,
        StRStatus,
        StRPc
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cause_q, cause_d;
    logic        mie_q, mie_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= 32'h0;
            cause_q <= 32'h0;
            mie_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cause_q <= cause_d;
            mie_q   <= mie_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        cause_d        = cause_q;
        mie_d          = mie_q;
        exc_ack        = 1'b0;
        mret_ack       = 1'b0;
        ins_csr_gnt    = 1'b0;
        csr_we         = 1'b0;
        csr_waddr      = 12'h0;
        csr_wdata      = 32'h0;
        csr_raddr      = 12'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        busy           = 1'b0;

        // While reset is held, IDLE pass-through would otherwise leak requests
        // onto the outputs; keep everything quiet until release.
        if (rst_n) begin
            unique case (state_q)
                StIdle: begin
                    if (exc_valid) begin
                        exc_ack = 1'b1;
                        pc_d    = exc_pc;
                        cause_d = exc_cause;
                        state_d = StTEpc;
                    end else if (mret_valid) begin
                        mret_ack = 1'b1;
                        state_d  = StRStatus;
                    end else if (irq && mie_q) begin
                        pc_d    = irq_pc;
                        cause_d = IrqCause;
                        state_d = StTEpc;
                    end else if (ins_csr_req) begin
                        ins_csr_gnt = 1'b1;
                        csr_we      = 1'b1;
                        csr_waddr   = ins_csr_addr;
                        csr_wdata   = ins_csr_wdata;
                        // Keep the MIE shadow coherent with software writes.
                        if (ins_csr_addr == CsrMstatus) begin
                            mie_d = ins_csr_wdata[3];
                        end
                    end
                end

                StTEpc: begin
                    busy      = 1'b1;
                    csr_we    = 1'b1;
                    csr_waddr = CsrMepc;
                    csr_wdata = pc_q;
                    state_d   = StTCause;
                end

                StTCause: begin
                    busy      = 1'b1;
                    csr_we    = 1'b1;
                    csr_waddr = CsrMcause;
                    csr_wdata = cause_q;
                    state_d   = StTStatus;
                end

                StTStatus: begin
                    // Read sees the pre-write value: MPIE<=MIE, MIE<=0, MPP<=11.
                    busy      = 1'b1;
                    csr_raddr = CsrMstatus;
                    csr_we    = 1'b1;
                    csr_waddr = CsrMstatus;
                    csr_wdata = (csr_rdata & ~32'h0000_1888) | 32'h0000_1800 |
                                {24'h0, csr_rdata[3], 7'h0};
                    mie_d     = 1'b0;
                    state_d   = StTVec;
                end

                StTVec: begin
                    // Direct mode only: mode bits of mtvec are ignored.
                    busy           = 1'b1;
                    csr_raddr      = CsrMtvec;
                    redirect_valid = 1'b1;
                    redirect_pc    = {csr_rdata[31:2], 2'b00};
                    state_d        = StIdle;
                end

                StRStatus: begin
                    // MIE<=MPIE, MPIE<=1; MPP stays 11 on an M-only core.
                    busy      = 1'b1;
                    csr_raddr = CsrMstatus;
                    csr_we    = 1'b1;
                    csr_waddr = CsrMstatus;
                    csr_wdata = (csr_rdata & ~32'h0000_0088) | 32'h0000_0080 |
                                {28'h0, csr_rdata[7], 3'h0};
                    mie_d     = csr_rdata[7];
                    state_d   = StRPc;
                end

                StRPc: begin
                    busy           = 1'b1;
                    csr_raddr      = CsrMepc;
                    redirect_valid = 1'b1;
                    redirect_pc    = csr_rdata;
                    state_d        = StIdle;
                end

                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl. A small CSR file model sits on the write
// port; expected writes and redirects (with the cycle they must appear in) are
// queued when stimulus is driven and retired by a monitor sampling at negedge.

module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic [31:0] exc_cause;
    logic        mret_valid;
    logic        irq;
    logic [31:0] irq_pc;
    logic        ins_csr_req;
    logic [11:0] ins_csr_addr;
    logic [31:0] ins_csr_wdata;
    logic [31:0] csr_rdata;
    logic        exc_ack;
    logic        mret_ack;
    logic        ins_csr_gnt;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic [11:0] csr_raddr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;

    trap_ctrl u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .exc_valid      (exc_valid),
        .exc_pc         (exc_pc),
        .exc_cause      (exc_cause),
        .mret_valid     (mret_valid),
        .irq            (irq),
        .irq_pc         (irq_pc),
        .ins_csr_req    (ins_csr_req),
        .ins_csr_addr   (ins_csr_addr),
        .ins_csr_wdata  (ins_csr_wdata),
        .csr_rdata      (csr_rdata),
        .exc_ack        (exc_ack),
        .mret_ack       (mret_ack),
        .ins_csr_gnt    (ins_csr_gnt),
        .csr_we         (csr_we),
        .csr_waddr      (csr_waddr),
        .csr_wdata      (csr_wdata),
        .csr_raddr      (csr_raddr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // CSR file model: combinational read, commit at end of cycle.
    logic [31:0] mstatus_m = 32'h0;
    logic [31:0] mtvec_m   = 32'h0;
    logic [31:0] mepc_m    = 32'h0;
    logic [31:0] mcause_m  = 32'h0;
    logic [31:0] other_m   = 32'h0;

    always_comb begin
        csr_rdata = 32'h0;
        case (csr_raddr)
            12'h300: csr_rdata = mstatus_m;
            12'h305: csr_rdata = mtvec_m;
            12'h341: csr_rdata = mepc_m;
            12'h342: csr_rdata = mcause_m;
            default: csr_rdata = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (csr_we) begin
            case (csr_waddr)
                12'h300: mstatus_m <= csr_wdata;
                12'h305: mtvec_m   <= csr_wdata;
                12'h341: mepc_m    <= csr_wdata;
                12'h342: mcause_m  <= csr_wdata;
                default: other_m   <= csr_wdata;
            endcase
        end
    end

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        int          at;
    } wr_t;

    typedef struct {
        logic [31:0] pc;
        int          at;
    } rd_t;

    wr_t wr_q[$];
    rd_t rd_q[$];

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: every write / redirect must match the head of its queue.
    always @(negedge clk) begin
        if (csr_we) begin
            if (wr_q.size() == 0) begin
                check_val("unexpected_we", {31'h0, csr_we}, 32'h0);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                check_val("we_addr", {20'h0, csr_waddr}, {20'h0, w.addr});
                check_val("we_data", csr_wdata, w.data);
                check_val("we_cycle", cyc, w.at);
            end
        end
        if (redirect_valid) begin
            if (rd_q.size() == 0) begin
                check_val("unexpected_redirect", {31'h0, redirect_valid}, 32'h0);
            end else begin
                rd_t r;
                r = rd_q.pop_front();
                check_val("redir_pc", redirect_pc, r.pc);
                check_val("redir_cycle", cyc, r.at);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, "_we"}, {31'h0, csr_we}, 32'h0);
        check_val({tag, "_acks"}, {29'h0, exc_ack, mret_ack, ins_csr_gnt}, 32'h0);
        check_val({tag, "_redir"}, {31'h0, redirect_valid}, 32'h0);
        check_val({tag, "_busy"}, {31'h0, busy}, 32'h0);
        check_val({tag, "_buses"}, {20'h0, csr_waddr} | csr_wdata | {20'h0, csr_raddr} |
                  redirect_pc, 32'h0);
    endtask

    task automatic ins_write(input logic [11:0] addr, input logic [31:0] data);
        ins_csr_req   = 1'b1;
        ins_csr_addr  = addr;
        ins_csr_wdata = data;
        wr_q.push_back('{addr, data, cyc});
        @(negedge clk);
        check_val("ins_gnt", {31'h0, ins_csr_gnt}, 32'h1);
        step();
        ins_csr_req = 1'b0;
    endtask

    // Full ecall entry; new_status is the expected mstatus after entry.
    task automatic ecall(input logic [31:0] pc, input logic [31:0] cause,
                         input logic [31:0] new_status, input logic [31:0] vec);
        int c0;
        c0 = cyc;
        exc_valid = 1'b1;
        exc_pc    = pc;
        exc_cause = cause;
        wr_q.push_back('{12'h341, pc, c0 + 1});
        wr_q.push_back('{12'h342, cause, c0 + 2});
        wr_q.push_back('{12'h300, new_status, c0 + 3});
        rd_q.push_back('{vec, c0 + 4});
        @(negedge clk);
        check_val("exc_ack", {31'h0, exc_ack}, 32'h1);
        step();
        exc_valid = 1'b0;
        @(negedge clk);
        check_val("busy_in_seq", {31'h0, busy}, 32'h1);
        repeat (4) step();
        @(negedge clk);
        check_val("busy_after_trap", {31'h0, busy}, 32'h0);
    endtask

    initial begin
        int c0;
        rst_n         = 1'b0;
        exc_valid     = 1'b0;
        exc_pc        = 32'h0;
        exc_cause     = 32'h0;
        mret_valid    = 1'b0;
        irq           = 1'b0;
        irq_pc        = 32'h0;
        ins_csr_req   = 1'b0;
        ins_csr_addr  = 12'h0;
        ins_csr_wdata = 32'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        step();
        rst_n = 1'b1;
        step();

        // Pass-through write of mtvec, then mstatus with MIE=1.
        ins_write(12'h305, 32'h8000_0100);
        ins_write(12'h300, 32'h0000_0008);

        // ecall entry.
        ecall(32'h8000_0040, 32'h0000_000b, 32'h0000_1880, 32'h8000_0100);
        check_val("mepc_model", mepc_m, 32'h8000_0040);
        check_val("mcause_model", mcause_m, 32'h0000_000b);
        step();

        // mret: mstatus 0x1880 -> 0x1888, redirect to mepc two cycles later.
        c0 = cyc;
        mret_valid = 1'b1;
        wr_q.push_back('{12'h300, 32'h0000_1888, c0 + 1});
        rd_q.push_back('{32'h8000_0040, c0 + 2});
        @(negedge clk);
        check_val("mret_ack", {31'h0, mret_ack}, 32'h1);
        step();
        mret_valid = 1'b0;
        repeat (2) step();

        // irq (mie restored by mret) beats a simultaneous CSR write; the held
        // write is granted once the trap completes and mie is cleared.
        c0 = cyc;
        irq           = 1'b1;
        irq_pc        = 32'h8000_0200;
        ins_csr_req   = 1'b1;
        ins_csr_addr  = 12'h340;
        ins_csr_wdata = 32'h0000_1234;
        wr_q.push_back('{12'h341, 32'h8000_0200, c0 + 1});
        wr_q.push_back('{12'h342, 32'h8000_0007, c0 + 2});
        wr_q.push_back('{12'h300, 32'h0000_1880, c0 + 3});
        rd_q.push_back('{32'h8000_0100, c0 + 4});
        wr_q.push_back('{12'h340, 32'h0000_1234, c0 + 5});
        @(negedge clk);
        check_val("irq_no_gnt", {31'h0, ins_csr_gnt}, 32'h0);
        check_val("irq_no_ack", {31'h0, exc_ack}, 32'h0);
        repeat (5) step();
        @(negedge clk);
        check_val("held_gnt", {31'h0, ins_csr_gnt}, 32'h1);
        step();
        ins_csr_req = 1'b0;
        // irq still high but mie is 0: must stay ignored.
        repeat (3) begin
            @(negedge clk);
            check_val("irq_masked_busy", {31'h0, busy}, 32'h0);
            step();
        end
        irq = 1'b0;
        check_val("mcause_irq", mcause_m, 32'h8000_0007);

        // Reset in T_CAUSE abandons the sequence.
        c0 = cyc;
        exc_valid = 1'b1;
        exc_pc    = 32'h8000_0080;
        exc_cause = 32'h0000_000b;
        wr_q.push_back('{12'h341, 32'h8000_0080, c0 + 1});
        step();
        exc_valid = 1'b0;
        step();
        rst_n = 1'b0;
        @(negedge clk);
        check_quiet("mid_reset");
        repeat (2) step();
        rst_n = 1'b1;
        repeat (6) step();
        check_val("mcause_kept", mcause_m, 32'h8000_0007);
        check_val("mepc_kept", mepc_m, 32'h8000_0080);

        // Fresh sequence after reset; MIE was 0 so MPIE ends up 0.
        ecall(32'h8000_0300, 32'h0000_000b, 32'h0000_1800, 32'h8000_0100);
        step();
        step();

        check_val("wr_q_empty", wr_q.size(), 32'h0);
        check_val("rd_q_empty", rd_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Trap sequencer for the machine-mode CSR file. It owns the CSR file's single write port and arbitrates it between instruction-level CSR writes and multi-cycle trap sequences: ecall entry, interrupt entry and mret return. Each sequence updates mepc, mcause and mstatus in a fixed order, then issues a one-cycle PC redirect to the IFU. It sits between IDU/EXU and the CSR file.

## Interface
- No parameters.
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- exc_valid  in  1  ecall detected; held until exc_ack
- exc_pc  in  32  PC of the ecall
- exc_cause  in  32  cause code (0x0000000b for M-mode ecall)
- mret_valid  in  1  mret detected; held until mret_ack
- irq  in  1  level machine timer interrupt pending
- irq_pc  in  32  PC of next unretired instruction, used as mepc for interrupts
- ins_csr_req  in  1  instruction CSR write request
- ins_csr_addr  in  12  target CSR address
- ins_csr_wdata  in  32  write data
- csr_rdata  in  32  combinational read data from the CSR file for csr_raddr
- exc_ack / mret_ack / ins_csr_gnt  out  1  one-cycle acceptance pulses
- csr_we  out  1  CSR file write enable
- csr_waddr  out  12  write address
- csr_wdata  out  32  write data
- csr_raddr  out  12  read address
- redirect_valid  out  1  one-cycle PC redirect
- redirect_pc  out  32  redirect target
- busy  out  1  high in every non-IDLE state; upstream stalls

## Operation
- Internal registers:
  - state
  - pc_q[31:0], cause_q[31:0]
  - mie_q: shadow of mstatus.MIE. Reset 0. Updated on every mstatus write issued by this block.
- States: IDLE, T_EPC, T_CAUSE, T_STATUS, T_VEC, R_STATUS, R_PC.
- IDLE priority is exc_valid > mret_valid > (irq & mie_q) > ins_csr_req.
  - Exception: exc_ack=1; pc_q<=exc_pc; cause_q<=exc_cause; go to T_EPC.
  - Interrupt: no ack pulse; pc_q<=irq_pc; cause_q<=0x80000007; go to T_EPC.
  - mret: mret_ack=1; go to R_STATUS.
  - CSR write with no trap event:
    - Pass through in the same cycle: csr_we=1, csr_waddr=ins_csr_addr, csr_wdata=ins_csr_wdata, ins_csr_gnt=1; stay in IDLE.
    - If ins_csr_addr==0x300, mie_q<=ins_csr_wdata[3].
  - A request that loses arbitration gets no grant and must be held by the requester.
- T_EPC: write 0x341 <= pc_q.
- T_CAUSE: write 0x342 <= cause_q.
- T_STATUS:
  - csr_raddr=0x300.
  - Write 0x300 <= (old & ~0x1888) | 0x1800 | (old[3]<<7), where old=csr_rdata. This sets MPIE=MIE, MIE=0, MPP=11.
  - mie_q<=0.
- T_VEC:
  - csr_raddr=0x305; csr_we=0.
  - redirect_valid=1, redirect_pc={csr_rdata[31:2],2'b00} (direct mode only).
  - Go to IDLE.
- R_STATUS:
  - csr_raddr=0x300.
  - Write 0x300 <= (old & ~0x88) | 0x80 | (old[7]<<3). This sets MIE=MPIE, MPIE=1; MPP stays 11 because the core is M-only.
  - mie_q<=old[7].
- R_PC: csr_raddr=0x341; redirect_valid=1, redirect_pc=csr_rdata; go to IDLE.
- ins_csr_gnt is 0 outside IDLE; busy stays high through every state from T_EPC/R_STATUS to T_VEC/R_PC.
- csr_raddr is 0x000 when not used.

## Timing
- Reset (async, any state) forces:
  - state=IDLE, pc_q=0, cause_q=0, mie_q=0.
  - All outputs 0: csr_we, acks, grant, redirect_valid, busy, and all address/data buses.
- Outputs are combinational from state and registers. The CSR file commits csr_we at the end of the cycle in which it is asserted.
- Trap entry, with acceptance in cycle 0:
  - cycle 1: mepc written
  - cycle 2: mcause written
  - cycle 3: mstatus written
  - cycle 4: redirect_valid
  - cycle 5: IDLE, new request acceptable
- mret, with acceptance in cycle 0: cycle 1 mstatus written; cycle 2 redirect.
- Reads in T_STATUS and R_STATUS see the pre-write value in the same cycle, because the read is combinational and the write commits at end of cycle.
- Simultaneous exc_valid and ins_csr_req in IDLE: the exception wins; no grant that cycle.
- irq raised while busy is ignored until IDLE. It is taken only if mie_q is 1 at that point.
- An ins_csr write to 0x300 in cycle N makes irq eligible from cycle N+1.
- Reset asserted mid-sequence abandons it. No redirect is produced, and CSR contents already written are not rolled back.

## Test plan
- Reset with all inputs 0: every output 0, busy=0. Release reset, then ins_csr_req to 0x305 with 0x80000100: same-cycle csr_we=1, csr_waddr=0x305, ins_csr_gnt=1.
- mstatus=0x00000008, exc_valid with exc_pc=0x80000040 and cause 0xb: mepc=0x80000040, mcause=0xb, mstatus=0x00001880; redirect_pc=0x80000100 exactly 4 cycles after exc_ack.
- mret after the above: mstatus=0x00001888, redirect_pc=0x80000040 two cycles after mret_ack, mie_q=1.
- With mie_q=1, assert irq with irq_pc=0x80000200 and ins_csr_req together: interrupt taken, no grant, mcause=0x80000007, mepc=0x80000200. With mie_q=0, irq is ignored.
- Assert rst_n low in T_CAUSE: outputs 0 immediately; no redirect; after release, the next exc_valid starts a fresh sequence.
